// File: rtl/multi_message_printer.sv
// Prints one of NUM_MSGS NUL-terminated ROM messages through a UART tx core,
// selected by a trigger byte on the rx stream and cancellable with an abort byte.
module multi_message_printer #(
    parameter int          NUM_MSGS   = 4,
    parameter int          MAX_LEN    = 16,
    parameter logic [7:0]  TRIG_BASE  = 8'h30,
    parameter logic [7:0]  ABORT_CHAR = 8'h1B,
    parameter int          SEL_W      = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1,
    parameter int          OFF_W      = $clog2(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   new_rx_data,
    output logic [7:0]             tx_data,
    output logic                   new_tx_data,
    input  logic                   tx_busy,
    output logic [SEL_W+OFF_W-1:0] rom_addr,
    input  logic [7:0]             rom_data,
    output logic                   busy,
    output logic                   done,
    output logic [SEL_W-1:0]       msg_sel
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FETCH  = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [OFF_W-1:0] off_q, off_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             new_tx_q, new_tx_d;
    logic             done_q, done_d;

    // 9-bit difference so bytes below TRIG_BASE wrap high and fail the range test
    logic [8:0] rx_rel;
    logic       is_trig;
    logic       is_abort;
    logic       off_last;

    assign rx_rel   = {1'b0, rx_data} - {1'b0, TRIG_BASE};
    assign is_trig  = new_rx_data && (rx_rel < 9'(NUM_MSGS));
    assign is_abort = new_rx_data && (rx_data == ABORT_CHAR);
    assign off_last = (off_q == OFF_W'(MAX_LEN - 1));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        off_d     = off_q;
        tx_data_d = tx_data_q;
        new_tx_d  = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                off_d = '0;
                if (is_trig) begin
                    sel_d   = rx_rel[SEL_W-1:0];
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (is_abort) begin
                    off_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                // Abort wins over a send that would otherwise fire this cycle
                if (is_abort) begin
                    off_d   = '0;
                    state_d = ST_IDLE;
                end else if (rom_data == 8'h00) begin
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else if (!tx_busy) begin
                    tx_data_d = rom_data;
                    new_tx_d  = 1'b1;
                    if (off_last) begin
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        off_d   = off_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FINISH: begin
                off_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                off_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            off_q     <= '0;
            tx_data_q <= 8'h00;
            new_tx_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            off_q     <= off_d;
            tx_data_q <= tx_data_d;
            new_tx_q  <= new_tx_d;
            done_q    <= done_d;
        end
    end

    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_q;
    assign done        = done_q;
    assign busy        = (state_q != ST_IDLE);
    assign msg_sel     = sel_q;
    assign rom_addr    = {sel_q, off_q};

endmodule

// File: tb/tb_multi_message_printer.sv
// Scoreboard bench for multi_message_printer: expected bytes and done events are
// queued by the stimulus and consumed by a monitor that watches the DUT outputs.
module tb_multi_message_printer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic       tx_busy;
    logic [5:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic       busy;
    logic       done;
    logic [1:0] msg_sel;

    logic [7:0] rom_mem [64];

    multi_message_printer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .busy        (busy),
        .done        (done),
        .msg_sel     (msg_sel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         trig_cyc = 0;
    int         strobe_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         strobe_cyc_q[$];
    logic [7:0] exp_q[$];
    int         done_q[$];
    logic [5:0] max_addr = 6'd0;
    logic       busy_model_en = 1'b0;
    int         tx_cnt = 0;
    logic       tx_busy_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data     = b;
        new_rx_data = 1'b1;
        trig_cyc    = cyc;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
        $display("rx byte 0x%02h at cycle %0d", b, trig_cyc);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        @(negedge clk);
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    task automatic wait_strobes(input int target, input int bound);
        int n = 0;
        while (strobe_cnt < target && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("strobes_reached", (strobe_cnt >= target), 1'b1);
    endtask

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    initial begin
        int base;
        int dbase;
        string m1;

        for (int i = 0; i < 64; i++) rom_mem[i] = 8'h00;
        rom_mem[0] = "H"; rom_mem[1] = "i";
        for (int i = 0; i < 16; i++) rom_mem[16 + i] = 8'h41 + 8'(i);
        rom_mem[32] = "O"; rom_mem[33] = "k";
        rom_mem[48] = 8'h00; rom_mem[49] = "X";
        m1 = "ABCDEFGHIJKLMNOP";

        rst_n = 1'b0; rx_data = 8'h00; new_rx_data = 1'b0; tx_busy = 1'b0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(posedge clk);
                #1;
                if (busy_model_en) begin
                    if (tx_cnt > 0) tx_cnt--;
                    if (new_tx_data) tx_cnt = 5;
                    tx_busy = (tx_cnt > 0);
                end else begin
                    tx_cnt  = 0;
                    tx_busy = 1'b0;
                end
            end
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (new_tx_data) begin
                        strobe_cnt++;
                        strobe_cyc_q.push_back(cyc);
                        $display("tx strobe 0x%02h at cycle %0d", tx_data, cyc);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_strobe", {24'd0, tx_data}, 32'hFFFF_FFFF);
                        end else begin
                            chk("tx_byte", tx_data, exp_q.pop_front());
                        end
                        chk("strobe_while_tx_busy", tx_busy_prev, 1'b0);
                    end
                    if (done) begin
                        done_cnt++;
                        done_cyc = cyc;
                        $display("done pulse msg_sel=%0d at cycle %0d", msg_sel, cyc);
                        if (done_q.size() == 0) begin
                            chk("unexpected_done", 32'd1, 32'd0);
                        end else begin
                            chk("done_msg_sel", msg_sel, done_q.pop_front());
                        end
                    end
                    if (busy && rom_addr > max_addr) max_addr = rom_addr;
                end
                tx_busy_prev = tx_busy;
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_new_tx", new_tx_data, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_msg_sel", msg_sel, 2'd0);
        chk("rst_rom_addr", rom_addr, 6'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // msg0 "Hi", no back-pressure
        strobe_cyc_q.delete();
        push_str("Hi"); done_q.push_back(0);
        base = strobe_cnt;
        send_rx("0");
        wait_idle(100);
        chk("m0_count", strobe_cnt - base, 2);
        chk("m0_first_lat", strobe_cyc_q[0] - trig_cyc, 3);
        chk("m0_gap", strobe_cyc_q[1] - strobe_cyc_q[0], 2);
        chk("m0_done_lat", done_cyc - trig_cyc, 7);

        // msg1 full 16-byte slot, no terminator
        strobe_cyc_q.delete();
        max_addr = 6'd0;
        push_str(m1); done_q.push_back(1);
        base = strobe_cnt; dbase = done_cnt;
        send_rx("1");
        wait_idle(200);
        chk("m1_count", strobe_cnt - base, 16);
        chk("m1_max_addr", max_addr, 6'h1F);
        chk("m1_done_count", done_cnt - dbase, 1);
        chk("m1_done_lat", done_cyc - trig_cyc, 33);

        // msg0 with tx_busy held 5 cycles before each send
        strobe_cyc_q.delete();
        busy_model_en = 1'b1;
        push_str("Hi"); done_q.push_back(0);
        base = strobe_cnt;
        send_rx("0");
        tx_cnt = 5;
        wait_idle(200);
        chk("bp_count", strobe_cnt - base, 2);
        chk("bp_gap", strobe_cyc_q[1] - strobe_cyc_q[0], 6);
        chk("bp_tx_data_hold", tx_data, "i");
        busy_model_en = 1'b0;
        repeat (2) @(posedge clk);

        // Abort msg1 after three bytes, then print msg2
        exp_q.push_back("A"); exp_q.push_back("B"); exp_q.push_back("C");
        base = strobe_cnt; dbase = done_cnt;
        send_rx("1");
        wait_strobes(base + 3, 50);
        send_rx(8'h1B);
        chk("abort_busy", busy, 1'b0);
        repeat (10) @(negedge clk);
        chk("abort_count", strobe_cnt - base, 3);
        chk("abort_no_done", done_cnt - dbase, 0);
        strobe_cyc_q.delete();
        push_str("Ok"); done_q.push_back(2);
        base = strobe_cnt;
        send_rx("2");
        wait_idle(100);
        chk("m2_count", strobe_cnt - base, 2);
        chk("m2_first_lat", strobe_cyc_q[0] - trig_cyc, 3);

        // Non-trigger bytes in IDLE, trigger mid-print
        send_rx("7");
        chk("idle_7_busy", busy, 1'b0);
        send_rx("A");
        chk("idle_A_busy", busy, 1'b0);
        send_rx(8'h1B);
        chk("idle_esc_busy", busy, 1'b0);
        chk("idle_msg_sel", msg_sel, 2'd2);
        push_str("Hi"); done_q.push_back(0);
        base = strobe_cnt;
        send_rx("0");
        wait_strobes(base + 1, 50);
        send_rx("2");
        wait_idle(100);
        chk("midtrig_count", strobe_cnt - base, 2);
        chk("midtrig_msg_sel", msg_sel, 2'd0);

        // Asynchronous reset mid-print
        push_str(m1);
        base = strobe_cnt;
        send_rx("1");
        wait_strobes(base + 2, 50);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_new_tx", new_tx_data, 1'b0);
        chk("arst_tx_data", tx_data, 8'h00);
        chk("arst_done", done, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_msg_sel", msg_sel, 2'd0);
        chk("arst_rom_addr", rom_addr, 6'd0);
        exp_q.delete();
        done_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        push_str("Hi"); done_q.push_back(0);
        base = strobe_cnt;
        send_rx("0");
        wait_idle(100);
        chk("post_rst_count", strobe_cnt - base, 2);

        // Empty message
        base = strobe_cnt; dbase = done_cnt;
        done_q.push_back(3);
        send_rx("3");
        wait_idle(100);
        chk("m3_count", strobe_cnt - base, 0);
        chk("m3_done_count", done_cnt - dbase, 1);
        chk("m3_done_lat", done_cyc - trig_cyc, 3);

        repeat (3) @(negedge clk);
        chk("exp_bytes_left", exp_q.size(), 0);
        chk("exp_done_left", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
